// File: rtl/fp_div_if.sv
// Handshake bundle for the single-precision divider.
// master drives start/a/b; slave returns busy/done/result/div_by_zero.
interface fp_div_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/fp_div.sv
// IEEE-754 single divider: restoring radix-2, one quotient bit/cycle.
// Ports: clk, rst (async high), bus (fp_div_if.slave handshake + result).
module fp_div (
  input  logic     clk,
  input  logic     rst,
  fp_div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic [4:0]  cnt;
  logic [25:0] rem;
  logic [24:0] quo;
  logic [23:0] nb;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic        sign;
  logic        special;
  logic        specialDbz;

  logic [31:0] resultQ;
  logic        doneQ;
  logic        dbzQ;

  logic        aZero;
  logic        bZero;
  logic        geq;
  logic [25:0] remSub;
  logic [9:0]  expWide;
  logic [22:0] frac;
  logic        unusedExpHi;

  assign aZero = (bus.a[30:0] == 31'd0);
  assign bZero = (bus.b[30:0] == 31'd0);

  assign geq    = (rem >= {2'b00, nb});
  assign remSub = rem - {2'b00, nb};

  // Q[24] set means the mantissa ratio was in [1,2).
  assign expWide = {2'b00, ea} - {2'b00, eb}
                 + (quo[24] ? 10'd127 : 10'd126);
  assign frac    = quo[24] ? quo[23:1] : quo[22:0];

  // Exponent wraps modulo 256; the top bits are intentionally dropped.
  assign unusedExpHi = ^expWide[9:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          // Zero operands bypass the iteration entirely.
          stateNext = (aZero || bZero) ? NORM : DIV;
        end
      end
      DIV: begin
        if (cnt == 5'd0) begin
          stateNext = NORM;
        end
      end
      NORM:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    unique case (1'b1)
      (state == DIV):  bus.busy = 1'b1;
      (state == NORM): bus.busy = 1'b1;
      default:         bus.busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 5'd0;
      rem        <= 26'd0;
      quo        <= 25'd0;
      nb         <= 24'd0;
      ea         <= 8'd0;
      eb         <= 8'd0;
      sign       <= 1'b0;
      special    <= 1'b0;
      specialDbz <= 1'b0;
      resultQ    <= 32'd0;
      doneQ      <= 1'b0;
      dbzQ       <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            ea         <= bus.a[30:23];
            eb         <= bus.b[30:23];
            sign       <= bus.a[31] ^ bus.b[31];
            rem        <= {3'b001, bus.a[22:0]};
            nb         <= {1'b1, bus.b[22:0]};
            quo        <= 25'd0;
            cnt        <= 5'd24;
            special    <= aZero | bZero;
            specialDbz <= bZero;
          end
        end
        DIV: begin
          if (geq) begin
            quo <= {quo[23:0], 1'b1};
            rem <= {remSub[24:0], 1'b0};
          end else begin
            quo <= {quo[23:0], 1'b0};
            rem <= {rem[24:0], 1'b0};
          end
          if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
          end
        end
        NORM: begin
          doneQ <= 1'b1;
          dbzQ  <= specialDbz;
          if (specialDbz) begin
            resultQ <= {sign, 8'hFF, 23'd0};
          end else if (special) begin
            resultQ <= 32'd0;
          end else begin
            resultQ <= {sign, expWide[7:0], frac};
          end
        end
        default: begin
          doneQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done        = doneQ;
  assign bus.result      = resultQ;
  assign bus.div_by_zero = dbzQ;

endmodule
